serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin computed one full-subtractor stage per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             Bout
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_next;

    // One full-subtractor stage on the current LSBs; the difference bit enters at the MSB.
    assign a_bit    = a_reg[0];
    assign b_bit    = b_reg[0];
    assign d_bit    = a_bit ^ b_bit ^ borrow;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    assign res_ext  = {d_bit, res_reg};
    assign res_next = res_ext[WIDTH:1];

    assign In_ready  = (state == ST_IDLE);
    assign Out_valid = (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so Diff/Bout read as zero after reset.
            state   <= ST_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            Diff    <= '0;
            Bout    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (In_valid) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        borrow <= Bin;
                        cnt    <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= res_next;
                    borrow  <= br_next;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Diff  <= res_next;
                        Bout  <= br_next;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (Out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are kept aside because a_reg/b_reg are consumed by the shift.
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            Ovf   <= 1'b0;
        end else if (state == ST_IDLE && In_valid) begin
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
        end else if (state == ST_SHIFT && cnt == LAST) begin
            Ovf <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end
`endif

endmodule
